q_event_window: RTL and testbench

//   Downstream consumer of the sequence-detector FSM output Q (Mealy or Moore variant).

---
 rtl/q_event_window.sv | 149 ++++++++++++++
 tb/tb_q_event_window.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_event_window.sv
// Counts rising edges of the detector output Q over fixed WINDOW-cycle windows and
// hands each window's count to a consumer over valid/ready, flagging saturation and drops.
module q_event_window #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Q,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    input  logic             ready,
    output logic             overflow,
    output logic             dropped
);

    localparam int               WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1'b1);
    localparam logic [CNT_W-1:0] ACC_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // The carry out of the (CNT_W+1)-bit sum decides the clamp.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{CNT_W{1'b0}}, inc};
        if (sum[CNT_W]) begin
            sat_inc = ACC_MAX;
        end else begin
            sat_inc = sum[CNT_W-1:0];
        end
    endfunction

    logic             q_d_r;
    logic [WIN_W-1:0] win_cnt_r;
    logic [CNT_W-1:0] acc_r;
    logic             acc_sat_r;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;
    logic             dropped_r;
    logic             ev_s;
    logic             close_s;
    logic [CNT_W-1:0] acc_nxt_s;
    logic             acc_sat_nxt_s;
    logic             load_s;
    logic             drop_s;

    assign ev_s    = Q & ~q_d_r;
    assign close_s = (win_cnt_r == WIN_LAST);

    // Accumulator value including this cycle's event, so a closing-cycle edge is reported.
    always_comb begin
        acc_nxt_s     = sat_inc(acc_r, ev_s);
        acc_sat_nxt_s = acc_sat_r | (ev_s & (acc_r == ACC_MAX));
    end

    // Output handshake next-state: load on close unless an unconsumed result blocks it.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            EMPTY: begin
                if (close_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            FULL: begin
                if (close_s && ready) begin
                    load_s      = 1'b1;
                    state_nxt_s = FULL;
                end else if (close_s) begin
                    drop_s      = 1'b1;
                    state_nxt_s = FULL;
                end else if (ready) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
    end

    // Edge-detect history follows Q every cycle, clear included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_d_r <= 1'b0;
        end else begin
            q_d_r <= Q;
        end
    end

    // Window counter, accumulator and output registers; clear restarts the window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt_r  <= {WIN_W{1'b0}};
            acc_r      <= {CNT_W{1'b0}};
            acc_sat_r  <= 1'b0;
            state_r    <= EMPTY;
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
            dropped_r  <= 1'b0;
        end else if (clear) begin
            win_cnt_r  <= {WIN_W{1'b0}};
            acc_r      <= {CNT_W{1'b0}};
            acc_sat_r  <= 1'b0;
            state_r    <= EMPTY;
            overflow_r <= 1'b0;
            dropped_r  <= 1'b0;
        end else begin
            if (close_s) begin
                win_cnt_r <= {WIN_W{1'b0}};
                acc_r     <= {CNT_W{1'b0}};
                acc_sat_r <= 1'b0;
            end else begin
                win_cnt_r <= win_cnt_r + WIN_ONE;
                acc_r     <= acc_nxt_s;
                acc_sat_r <= acc_sat_nxt_s;
            end
            state_r <= state_nxt_s;
            if (load_s) begin
                count_r    <= acc_nxt_s;
                overflow_r <= acc_sat_nxt_s;
            end
            if (drop_s) begin
                dropped_r <= 1'b1;
            end
        end
    end

    assign count    = count_r;
    assign valid    = (state_r == FULL);
    assign overflow = overflow_r;
    assign dropped  = dropped_r;

endmodule

// File: tb/tb_q_event_window.sv
// Self-checking bench for q_event_window: two instances (CNT_W=8 and CNT_W=2) share stimulus
// and are compared every cycle against a per-window event-count reference model.
module tb_q_event_window;

    localparam int WIN = 16;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       Q     = 1'b0;
    logic       clear = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] count_a;
    logic       valid_a, ovf_a, drop_a;
    logic [1:0] count_b;
    logic       valid_b, ovf_b, drop_b;
    logic [15:0] obs;

    int errors = 0;
    int checks = 0;

    int m_pos[2];
    int m_ev[2];
    int m_count[2];
    bit m_valid[2];
    bit m_ov[2];
    bit m_drop[2];
    bit m_prevq[2];

    q_event_window #(.WINDOW(WIN), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .Q(Q), .clear(clear), .count(count_a),
        .valid(valid_a), .ready(ready), .overflow(ovf_a), .dropped(drop_a)
    );

    q_event_window #(.WINDOW(WIN), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .Q(Q), .clear(clear), .count(count_b),
        .valid(valid_b), .ready(ready), .overflow(ovf_b), .dropped(drop_b)
    );

    assign obs = {valid_a, count_a, ovf_a, drop_a, valid_b, count_b, ovf_b, drop_b};

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pos[i] = 0; m_ev[i] = 0; m_count[i] = 0;
            m_valid[i] = 1'b0; m_ov[i] = 1'b0; m_drop[i] = 1'b0; m_prevq[i] = 1'b0;
        end
    endtask

    // One clock edge of the reference: whole-window event totals, clamped when reported.
    task automatic model_edge();
        int maxc;
        for (int i = 0; i < 2; i++) begin
            maxc = (i == 0) ? 255 : 3;
            if (clear) begin
                m_pos[i] = 0; m_ev[i] = 0; m_valid[i] = 1'b0; m_ov[i] = 1'b0; m_drop[i] = 1'b0;
            end else begin
                if (Q && !m_prevq[i]) m_ev[i]++;
                if (m_pos[i] == WIN - 1) begin
                    if (!m_valid[i] || ready) begin
                        m_valid[i] = 1'b1;
                        m_count[i] = (m_ev[i] > maxc) ? maxc : m_ev[i];
                        m_ov[i]    = (m_ev[i] > maxc);
                    end else begin
                        m_drop[i] = 1'b1;
                    end
                    m_ev[i] = 0; m_pos[i] = 0;
                end else begin
                    m_pos[i]++;
                    if (ready) m_valid[i] = 1'b0;
                end
            end
            m_prevq[i] = Q;
        end
    endtask

    function automatic logic [15:0] exp_all();
        logic [7:0] ca;
        logic [1:0] cb;
        ca = 8'(m_count[0]);
        cb = 2'(m_count[1]);
        return {m_valid[0], ca, m_ov[0], m_drop[0], m_valid[1], cb, m_ov[1], m_drop[1]};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_clear(input logic rdy);
        clear = 1'b1; Q = 1'b0; ready = rdy;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        if (obs !== 16'd0) begin errors++; $display("FAIL reset_hold got=%h exp=0000", obs); end
        checks++;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        if (obs !== exp_all()) begin errors++; $display("FAIL reset_release got=%h exp=%h", obs, exp_all()); end
        checks++;
    endtask

    task automatic test_basic_window();
        do_clear(1'b1);
        for (int i = 0; i < WIN; i++) begin
            Q = (i < 6) && (i % 2 == 0); ready = 1'b1;
            tick();
            if (obs !== exp_all()) begin errors++; $display("FAIL basic cyc=%0d got=%h exp=%h", i, obs, exp_all()); end
            checks++;
        end
        if (valid_a !== 1'b1 || count_a !== 8'd3 || ovf_a !== 1'b0) begin
            errors++; $display("FAIL basic_result got v=%0b c=%0d o=%0b exp v=1 c=3 o=0", valid_a, count_a, ovf_a);
        end
        checks++;
        Q = 1'b0;
        tick();
        if (valid_a !== 1'b0) begin errors++; $display("FAIL basic_consume got v=%0b exp v=0", valid_a); end
        checks++;
    endtask

    task automatic test_closing_edge();
        do_clear(1'b1);
        for (int i = 0; i < 2 * WIN; i++) begin
            Q = (i == WIN - 1); ready = 1'b1;
            tick();
            if (obs !== exp_all()) begin errors++; $display("FAIL close_edge cyc=%0d got=%h exp=%h", i, obs, exp_all()); end
            checks++;
            if (i == WIN - 1 && (valid_a !== 1'b1 || count_a !== 8'd1)) begin
                errors++; $display("FAIL close_edge_incl got v=%0b c=%0d exp v=1 c=1", valid_a, count_a);
            end
            if (i == WIN - 1) checks++;
        end
        if (valid_a !== 1'b1 || count_a !== 8'd0) begin
            errors++; $display("FAIL close_edge_next got v=%0b c=%0d exp v=1 c=0", valid_a, count_a);
        end
        checks++;
    endtask

    task automatic test_saturation();
        do_clear(1'b1);
        for (int i = 0; i < WIN; i++) begin
            Q = (i < 10) && (i % 2 == 0); ready = 1'b1;
            tick();
            if (obs !== exp_all()) begin errors++; $display("FAIL sat cyc=%0d got=%h exp=%h", i, obs, exp_all()); end
            checks++;
        end
        if (count_b !== 2'd3 || ovf_b !== 1'b1 || count_a !== 8'd5 || ovf_a !== 1'b0) begin
            errors++; $display("FAIL sat_result got cb=%0d ob=%0b ca=%0d oa=%0b exp cb=3 ob=1 ca=5 oa=0",
                               count_b, ovf_b, count_a, ovf_a);
        end
        checks++;
    endtask

    task automatic test_backpressure();
        do_clear(1'b0);
        for (int i = 0; i < 2 * WIN; i++) begin
            Q = ((i < 4) || (i >= 16 && i < 24)) && (i % 2 == 0); ready = 1'b0;
            tick();
            if (obs !== exp_all()) begin errors++; $display("FAIL bp cyc=%0d got=%h exp=%h", i, obs, exp_all()); end
            checks++;
        end
        if (valid_a !== 1'b1 || count_a !== 8'd2 || drop_a !== 1'b1) begin
            errors++; $display("FAIL bp_hold got v=%0b c=%0d d=%0b exp v=1 c=2 d=1", valid_a, count_a, drop_a);
        end
        checks++;
        Q = 1'b0; ready = 1'b1;
        tick();
        if (valid_a !== 1'b0 || drop_a !== 1'b1) begin
            errors++; $display("FAIL bp_consume got v=%0b d=%0b exp v=0 d=1", valid_a, drop_a);
        end
        checks++;
        ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        if (obs !== exp_all() || drop_a !== 1'b1) begin
            errors++; $display("FAIL bp_sticky got=%h exp=%h d=%0b", obs, exp_all(), drop_a);
        end
        checks++;
        do_clear(1'b0);
        if (drop_a !== 1'b0 || drop_b !== 1'b0) begin
            errors++; $display("FAIL bp_clear got da=%0b db=%0b exp 0 0", drop_a, drop_b);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        do_clear(1'b0);
        for (int i = 0; i < 2 * WIN; i++) begin
            Q = (i == 2) || ((i >= 16 && i < 22) && (i % 2 == 0)); ready = (i == 2 * WIN - 1);
            tick();
            if (obs !== exp_all()) begin errors++; $display("FAIL b2b cyc=%0d got=%h exp=%h", i, obs, exp_all()); end
            checks++;
        end
        if (valid_a !== 1'b1 || count_a !== 8'd3 || drop_a !== 1'b0) begin
            errors++; $display("FAIL b2b_result got v=%0b c=%0d d=%0b exp v=1 c=3 d=0", valid_a, count_a, drop_a);
        end
        checks++;
        clear = 1'b1; Q = 1'b1; ready = 1'b0;
        tick();
        clear = 1'b0;
        if (valid_a !== 1'b0 || drop_a !== 1'b0) begin
            errors++; $display("FAIL b2b_clear got v=%0b d=%0b exp v=0 d=0", valid_a, drop_a);
        end
        checks++;
        ready = 1'b1;
        for (int i = 0; i < WIN; i++) begin
            tick();
            if (obs !== exp_all()) begin errors++; $display("FAIL b2b_post cyc=%0d got=%h exp=%h", i, obs, exp_all()); end
            checks++;
        end
        if (valid_a !== 1'b1 || count_a !== 8'd0) begin
            errors++; $display("FAIL clear_edge got v=%0b c=%0d exp v=1 c=0", valid_a, count_a);
        end
        checks++;
    endtask

    task automatic test_async_reset();
        do_clear(1'b0);
        for (int i = 0; i < WIN + 3; i++) begin
            Q = (i % 4 == 0); ready = 1'b0;
            tick();
            if (obs !== exp_all()) begin errors++; $display("FAIL ar_pre cyc=%0d got=%h exp=%h", i, obs, exp_all()); end
            checks++;
        end
        #2;
        reset = 1'b0;
        #1;
        if (obs !== 16'd0) begin errors++; $display("FAIL async_reset got=%h exp=0000", obs); end
        checks++;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        Q = 1'b1; ready = 1'b1;
        for (int i = 0; i < WIN; i++) begin
            tick();
            Q = 1'b0;
            if (obs !== exp_all()) begin errors++; $display("FAIL ar_post cyc=%0d got=%h exp=%h", i, obs, exp_all()); end
            checks++;
        end
        if (valid_a !== 1'b1 || count_a !== 8'd1) begin
            errors++; $display("FAIL ar_first got v=%0b c=%0d exp v=1 c=1", valid_a, count_a);
        end
        checks++;
    endtask

    task automatic test_random();
        int rmode;
        rmode = 1;
        for (int c = 0; c < 1200; c++) begin
            if (c % WIN == 0) rmode = $urandom_range(0, 2);
            Q     = 1'($urandom_range(0, 1));
            ready = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            clear = ($urandom_range(0, 99) == 0);
            tick();
            if (obs !== exp_all()) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", c, obs, exp_all()); end
            checks++;
        end
        clear = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_window();
        test_closing_edge();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
